jk_mod_counter: RTL
===================

// Module: jk_mod_counter
// PURPOSE
//  Synchronous modulo-N up/down counter. Each state bit is a JK flip-flop slice;
//  the next-state logic in this block drives that slice's J/K inputs.
//  Sits directly downstream of the single JK flip-flop cell and is the first
//  multi-bit consumer of it. Its count and terminal-count outputs feed the
//  later divider and sequencer stages.
// PARAMETERS
//  WIDTH    4   counter width in bits; must satisfy 2**WIDTH >= MODULUS
//  MODULUS  10  count range is 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk        in   1      single clock, rising-edge active
//  neg_clear  in   1      asynchronous, active-low reset
//  en         in   1      count enable
//  up         in   1      direction: 1 = increment, 0 = decrement
//  load       in   1      synchronous load strobe
//  load_val   in   WIDTH  value to load
//  clr_ovf    in   1      clears the sticky ovf flag
//  count      out  WIDTH  current count (JK slice outputs)
//  tc         out  1      terminal count (combinational)
//  ovf        out  1      sticky wrap flag (registered)
//  load_err   out  1      one-cycle pulse: the last load was out of range (registered)
// BEHAVIOUR
//  - Reset: neg_clear=0 forces count=0, ovf=0, load_err=0 immediately, with no clk edge.
//    Reset release is synchronous to clk; the first count action is the first edge after release.
//  - Priority at each rising edge: load > en > hold.
//  - load=1:
//    - If load_val < MODULUS: count <= load_val and load_err <= 0.
//    - Otherwise: count <= 0 and load_err <= 1 for exactly one cycle.
//    - en is ignored on that cycle. ovf is not changed by a load.
//  - en=1, load=0, up=1: count <= (count==MODULUS-1) ? 0 : count+1.
//  - en=1, load=0, up=0: count <= (count==0) ? MODULUS-1 : count-1.
//  - en=0, load=0: count holds; load_err <= 0.
//  - Latency: count reflects an action one clk edge after it is sampled.
//  - tc = en & ~load & (up ? count==MODULUS-1 : count==0).
//    tc is high in the cycle before a wrap, so stages can be cascaded.
//  - ovf:
//    - Set on the edge where a wrap occurs.
//    - Cleared on an edge where clr_ovf=1.
//    - If a wrap and clr_ovf=1 fall on the same edge, the set wins (ovf=1).
//  - Per-bit JK drive: nxt is the computed next count.
//    - j[i] = ~count[i] & nxt[i]
//    - k[i] = count[i] & ~nxt[i]
//    - A slice never sees J=K=1 except when it toggles, so its hold, set and clear modes are all exercised.
//  - All arithmetic is WIDTH bits and unsigned. Compare against MODULUS-1 and never rely on natural wrap,
//    except when MODULUS == 2**WIDTH, where both are equivalent.
//  - Direction change mid-count takes effect on the next enabled edge; there is no extra state.
//  - neg_clear asserted mid-operation overrides load and en at once.
// STRUCTURE
//  - Shared package (counter_pkg): CNT_MAX_WIDTH=16 and a localparam function that checks
//    MODULUS against WIDTH. Elaboration errors if 2**WIDTH < MODULUS or MODULUS < 2.
//  - One sub-module: jk_bit_slice.
//    - Ports: clk, neg_clear, j, k, q.
//    - JK truth table: 00 hold, 01 clear, 10 set, 11 toggle, with async clear.
//    - Instantiated WIDTH times with a generate loop.
//  - Top level holds the next-state mux, the wrap detect, and the ovf and load_err registers.
// TESTING
//  1. Reset: up=1, en=1, count reaches 7; pulse neg_clear=0 between edges
//     -> count=0, ovf=0 before the next edge.
//  2. Up wrap (WIDTH=4, MODULUS=10): en=1, up=1 from 0 for 10 edges
//     -> count runs 0..9,0; tc=1 only while count=9; ovf=1 after the 9->0 edge.
//  3. Down wrap: load 0, then en=1, up=0
//     -> tc=1 at count=0; next edge count=9 and ovf=1.
//     -> clr_ovf=1 with no wrap clears ovf; clr_ovf=1 on a wrap edge keeps ovf=1.
//  4. Load: load_val=6 with en=1 -> count=6, not 7.
//     -> load_val=12 -> count=0 and load_err=1 for one cycle, then 0.
//  5. Hold / direction: at count=3 with en=0 for 5 edges -> count stays 3.
//     -> en=1 with up toggling every edge -> 4,3,4,3.
//  6. Full-range config (WIDTH=3, MODULUS=8): count 7 up -> 0 with ovf=1.
//     -> Checker confirms no slice ever has J=K=1 unless it toggles on that edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and parameter checks for the modulo counter family.
// Imported by every counter stage.
package counter_pkg;

    localparam int CNT_MAX_WIDTH = 16;

    function automatic bit mod_fits(input int w, input int m);
        return (w >= 1) && (w <= CNT_MAX_WIDTH)
            && (m >= 2) && (m <= (1 << w));
    endfunction

endpackage

// File: rtl/jk_mod_counter_bit_slice.sv
// One JK flip-flop state bit with asynchronous active-low clear.
// 00 hold, 01 clear, 10 set, 11 toggle.
module jk_bit_slice (
    input  logic clk,
    input  logic neg_clear,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00: q <= q;
                2'b01: q <= 1'b0;
                2'b10: q <= 1'b1;
                2'b11: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK bit slices.
// Terminal count is combinational so stages can cascade.
module jk_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             neg_clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             load_err
);

    if (!mod_fits(WIDTH, MODULUS)) begin : g_bad_cfg
        $error("jk_mod_counter: MODULUS does not fit WIDTH");
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_top;
    logic             at_zero;
    logic             load_ok;
    logic             wrap;

    always_comb begin
        at_top  = (count == TOP);
        at_zero = (count == '0);
        load_ok = (load_val <= TOP);
        nxt     = count;
        wrap    = 1'b0;
        unique case (1'b1)
            load: begin
                nxt = load_ok ? load_val : '0;
            end
            (!load && en && up): begin
                nxt  = at_top ? '0 : count + WIDTH'(1);
                wrap = at_top;
            end
            (!load && en && !up): begin
                nxt  = at_zero ? TOP : count - WIDTH'(1);
                wrap = at_zero;
            end
            default: begin
                nxt = count;
            end
        endcase
    end

    assign tc = en & ~load & (up ? at_top : at_zero);
    assign j  = ~count & nxt;
    assign k  = count & ~nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        jk_bit_slice u_slice (
            .clk       (clk),
            .neg_clear (neg_clear),
            .j         (j[i]),
            .k         (k[i]),
            .q         (count[i])
        );
    end

    // A wrap on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) begin
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (wrap) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            load_err <= load & ~load_ok;
        end
    end

endmodule
